// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;
    typedef enum logic [1:0] {FETCH, READY, DRAIN} fetch_state_e;
    localparam logic [31:0] NOP_INST         = 32'h0;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_unit_perf_cnt.sv
// if_perf_cnt: wrapping counters of consumed instructions and bubble cycles (IF_PERF_CNT_EN builds only).
module if_perf_cnt (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        consume,
    input  logic        bubble,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
);
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_q + 32'(consume);
            bubble_cnt_q <= bubble_cnt_q + 32'(bubble);
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and imem req/ack fetch FSM feeding the IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch_cnt/bubble_cnt performance counters.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        stall,
    input  logic        MEM_PCSrc,
    input  logic [31:0] MEM_Target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC4,
    output logic [31:0] IF_Inst,
    output logic        IF_Valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  target;

    assign target = MEM_Target & ~32'h3;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        drain_addr_d = drain_addr_q;
        case (state_q)
            FETCH: begin
                if (MEM_PCSrc) begin
                    pc_d = target;
                    // an unacknowledged request must be held at its original address
                    if (!imem_ack) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = READY;
                end
            end
            READY: begin
                if (MEM_PCSrc) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!stall) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (MEM_PCSrc) pc_d = target;
                if (imem_ack) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // gating with Clrn drops the request asynchronously while reset is held
    assign imem_req  = Clrn && (state_q != READY);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign IF_Valid  = (state_q == READY);
    assign IF_Inst   = IF_Valid ? inst_q : NOP_INST;
    assign IF_PC     = pc_q;
    assign IF_PC4    = pc_q + PC_STEP;

`ifdef IF_PERF_CNT_EN
    if_perf_cnt u_perf_cnt (
        .Clk       (Clk),
        .Clrn      (Clrn),
        .consume   (IF_Valid && !stall && !MEM_PCSrc),
        .bubble    (!IF_Valid && !stall),
        .fetch_cnt (fetch_cnt),
        .bubble_cnt(bubble_cnt)
    );
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench with a wait-configurable memory model and an expected-fetch scoreboard.
module tb_if_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        Clk = 0, Clrn = 1, stall = 0, MEM_PCSrc = 0;
    logic [31:0] MEM_Target = '0;
    logic        imem_req, imem_ack, IF_Valid;
    logic [31:0] imem_addr, imem_rdata, IF_PC, IF_PC4, IF_Inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt;
`endif
    int          errors = 0, checks = 0, mem_wait = 0, wcnt = 0;
    logic [31:0] sb[$];
    bit          seen = 0;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .Clk       (Clk),
        .Clrn      (Clrn),
        .stall     (stall),
        .MEM_PCSrc (MEM_PCSrc),
        .MEM_Target(MEM_Target),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .IF_PC     (IF_PC),
        .IF_PC4    (IF_PC4),
        .IF_Inst   (IF_Inst),
        .IF_Valid  (IF_Valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0F13;
    endfunction

    assign imem_ack   = imem_req && (wcnt == mem_wait);
    assign imem_rdata = imem_req ? inst_of(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge Clk or negedge Clrn) begin
        if (!Clrn) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // every newly presented instruction must match the next expected fetch
    always @(negedge Clk) begin
        logic [31:0] a;
        chk("pc4_inv", IF_PC4, IF_PC + 32'd4);
        if (!IF_Valid) begin
            chk("nop_inv", IF_Inst, 32'h0);
            seen = 0;
        end else if (!seen) begin
            seen = 1;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                a = sb.pop_front();
                chk("sb_pc", IF_PC, a);
                chk("sb_inst", IF_Inst, inst_of(a));
            end
        end
    end

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!IF_Valid && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk(tag, 32'(IF_Valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        #1 Clrn = 0;
        @(negedge Clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(IF_Valid), 32'd0);
        chk("rst_inst", IF_Inst, 32'h0);
        chk("rst_pc", IF_PC, RST_PC);
        chk("rst_pc4", IF_PC4, RST_PC + 32'd4);
        for (int i = 0; i < 4; i++) sb.push_back(RST_PC + 32'(4 * i));
        @(posedge Clk);
        #1 Clrn = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("zw_req", 32'(imem_req), 32'd1);
            chk("zw_addr", imem_addr, RST_PC + 32'(4 * i));
            chk("zw_valid0", 32'(IF_Valid), 32'd0);
            @(negedge Clk);
            chk("zw_valid1", 32'(IF_Valid), 32'd1);
            chk("zw_noreq", 32'(imem_req), 32'd0);
        end
        mem_wait = 3;
        sb.push_back(RST_PC + 32'd16);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("ws_req", 32'(imem_req), 32'd1);
            chk("ws_addr", imem_addr, RST_PC + 32'd16);
            chk("ws_valid0", 32'(IF_Valid), 32'd0);
            chk("ws_inst0", IF_Inst, 32'h0);
        end
        @(negedge Clk);
        chk("ws_valid1", 32'(IF_Valid), 32'd1);
        chk("ws_inst", IF_Inst, inst_of(RST_PC + 32'd16));
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("st_valid", 32'(IF_Valid), 32'd1);
            chk("st_noreq", 32'(imem_req), 32'd0);
            chk("st_pc", IF_PC, RST_PC + 32'd16);
            chk("st_inst", IF_Inst, inst_of(RST_PC + 32'd16));
        end
        stall = 0;
        @(negedge Clk);
        chk("st_pc_adv", IF_PC, RST_PC + 32'd20);
        chk("rd_addr0", imem_addr, RST_PC + 32'd20);
        MEM_PCSrc = 1;
        MEM_Target = 32'h0000_0103;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            MEM_PCSrc = 0;
            chk("dr_req", 32'(imem_req), 32'd1);
            chk("dr_addr", imem_addr, RST_PC + 32'd20);
            chk("dr_pc", IF_PC, 32'h0000_0100);
            chk("dr_valid", 32'(IF_Valid), 32'd0);
        end
        sb.push_back(32'h0000_0100);
        @(negedge Clk);
        chk("dr_next_req", 32'(imem_req), 32'd1);
        chk("dr_next_addr", imem_addr, 32'h0000_0100);
        mem_wait = 0;
        @(negedge Clk);
        chk("dr_valid1", 32'(IF_Valid), 32'd1);
        @(negedge Clk);
        chk("ra_addr0", imem_addr, 32'h0000_0104);
        stall = 1;
        MEM_PCSrc = 1;
        MEM_Target = 32'h0000_0200;
        sb.push_back(32'h0000_0200);
        @(negedge Clk);
        MEM_PCSrc = 0;
        chk("ra_valid", 32'(IF_Valid), 32'd0);
        chk("ra_inst", IF_Inst, 32'h0);
        chk("ra_req", 32'(imem_req), 32'd1);
        chk("ra_addr", imem_addr, 32'h0000_0200);
        @(negedge Clk);
        chk("ra_valid1", 32'(IF_Valid), 32'd1);
        MEM_PCSrc = 1;
        MEM_Target = 32'hFFFF_FFFE;
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0000_0000);
        @(negedge Clk);
        MEM_PCSrc = 0;
        stall = 0;
        chk("wr_valid", 32'(IF_Valid), 32'd0);
        chk("wr_pc", IF_PC, 32'hFFFF_FFFC);
        chk("wr_pc4", IF_PC4, 32'h0);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge Clk);
        chk("wr_valid1", 32'(IF_Valid), 32'd1);
        @(negedge Clk);
        chk("wr_addr0", imem_addr, 32'h0);
        chk("wr_pc0", IF_PC, 32'h0);
        @(negedge Clk);
        chk("wr_valid2", 32'(IF_Valid), 32'd1);
        mem_wait = 3;
        @(negedge Clk);
        chk("ar_req1", 32'(imem_req), 32'd1);
        chk("ar_addr1", imem_addr, 32'h4);
        #1 Clrn = 0;
        #1;
        chk("ar_req0", 32'(imem_req), 32'd0);
        chk("ar_pc", IF_PC, RST_PC);
        chk("ar_valid", 32'(IF_Valid), 32'd0);
        sb.push_back(RST_PC);
        @(posedge Clk);
        #2 Clrn = 1;
        mem_wait = 0;
        @(negedge Clk);
        chk("ar_restart_req", 32'(imem_req), 32'd1);
        chk("ar_restart_addr", imem_addr, RST_PC);
        wait_valid("ar_restart_valid");
        stall = 1;
        repeat (2) @(negedge Clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage pipeline and the producer side of the IF/ID pipeline register.
- Owns the PC and runs a req/ack handshake to instruction memory.
- Presents PC, PC+4 and the fetched instruction (NOP when none is ready) to IF/ID.
- Honours the pipeline's stall and MEM-stage branch/jump redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Clrn  in  1  asynchronous reset, active low.
stall  in  1  ID hazard stall; hold the presented instruction and PC.
MEM_PCSrc  in  1  branch/jump taken in MEM; redirect fetch.
MEM_Target  in  32  redirect target address; bits [1:0] are ignored.
imem_req  out  1  instruction memory request.
imem_addr  out  32  word-aligned fetch address.
imem_ack  in  1  memory has completed the request; imem_rdata is valid this cycle.
imem_rdata  in  32  instruction word.
IF_PC  out  32  PC of the presented instruction.
IF_PC4  out  32  IF_PC + 4.
IF_Inst  out  32  presented instruction; 32'h0 (NOP) when IF_Valid = 0.
IF_Valid  out  1  IF_Inst holds a real fetched instruction.

Behaviour:
- Reset, asynchronous while Clrn = 0:
  - PC = RESET_PC; state = FETCH.
  - imem_req = 0; IF_Valid = 0; IF_Inst = 0.
  - IF_PC = RESET_PC; IF_PC4 = RESET_PC + 4.
- States: FETCH, READY, DRAIN.
- FETCH:
  - imem_req = 1; imem_addr = PC.
  - On imem_ack: capture imem_rdata into the instruction register and go to READY.
  - Minimum latency from req to IF_Valid is 1 cycle (zero-wait memory: ack in the same cycle as req).
- READY:
  - imem_req = 0; IF_Valid = 1.
  - stall = 1: hold all outputs.
  - stall = 0: instruction is consumed at this edge; PC <= PC + 4; go to FETCH; IF_Valid deasserts next cycle.
- DRAIN:
  - imem_req stays 1 with the old address until imem_ack, because the handshake forbids withdrawing an unacknowledged request.
  - On ack: discard the data; go to FETCH at the already-updated PC.
- Redirect (MEM_PCSrc = 1) has priority over stall in every state:
  - PC <= {MEM_Target[31:2], 2'b00}.
  - IF_Valid drops to 0 next cycle.
  - FETCH with no ack: go to DRAIN.
  - FETCH with ack in the same cycle: discard data; go to FETCH.
  - READY: drop the held instruction; go to FETCH.
  - DRAIN: retarget PC; stay in DRAIN.
- Handshake rule: imem_addr is stable while imem_req = 1 and no ack has been seen.
- Arithmetic: PC + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- Invariants:
  - IF_PC4 = IF_PC + 4 at all times.
  - IF_Inst = 0 whenever IF_Valid = 0.
- Stall while not READY: no effect; an instruction still being fetched simply arrives later.
- Reset mid-request: imem_req drops immediately. Memory must tolerate an abandoned request across reset.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds two outputs.
  - fetch_cnt (32): +1 per instruction consumed, i.e. READY and !stall and !MEM_PCSrc.
  - bubble_cnt (32): +1 per cycle with IF_Valid = 0 and stall = 0.
  - Both reset to 0 and wrap.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - State enum {FETCH, READY, DRAIN}.
  - NOP_INST = 32'h0.
  - PC_STEP = 4.
  - Default RESET_PC.
- Main FSM and PC stay in one module.
- The optional counters live in sub-module if_perf_cnt, instantiated only under IF_PERF_CNT_EN.

Test Plan:
- Reset with RESET_PC = 32'h0040_0000 and zero-wait memory, no stall -> imem_addr sequence 0x00400000, 0x00400004, ...; IF_Valid high every other cycle; IF_PC4 = IF_PC + 4.
- Memory with 3 wait cycles -> imem_req held 4 cycles with stable address; IF_Inst = imem_rdata the cycle after ack; IF_Inst = 0 before that.
- stall held 5 cycles while READY -> IF_PC, IF_Inst and IF_Valid unchanged; no new request; PC advances only after stall drops.
- MEM_PCSrc with MEM_Target = 32'h0000_0103 during a waiting fetch -> request held to ack and data discarded; next request to 32'h0000_0100.
- MEM_PCSrc in the same cycle as imem_ack, with stall = 1 -> data discarded; next cycle FETCH at the target; IF_Valid = 0.
- PC = 32'hFFFF_FFFC consumed -> next imem_addr = 32'h0. Clrn pulsed low mid-request -> imem_req drops asynchronously; fetch restarts at RESET_PC.
